fpadd_pipe: RTL and testbench
=============================

# fpadd_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor for the datapath floating-point unit. It accepts one operand pair per cycle over a valid/ready handshake and returns the correctly rounded sum or difference three cycles later. Output rounding is round-to-nearest-even, with flush-to-zero on subnormals. It is the sequential, width-generic successor to the combinational single-precision `fpadd`, and default parameters give binary32 results bit-identical to it.

## Interface
- EXP_W, default 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, default 23: stored fraction width; total width W = 1+EXP_W+MAN_W.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all pipeline valids and outputs.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  1: compute a-b; 0: compute a+b.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- s  out  W  result.
- flags  out  3  {nv, of, nx}: invalid, overflow, inexact; qualified by out_valid.

## Operation
- Effective B sign = b.sign XOR sub.
- Subnormal inputs are flushed to signed zero before any arithmetic. This sets no flag.
- Special cases, resolved in stage 1 and carried to the output:
  - Any NaN operand gives the canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0). nv is set only for a signalling NaN input.
  - +inf plus -inf (after the effective sign) gives the canonical qNaN with nv=1.
  - inf plus finite gives that inf.
- Stage 1 (unpack/align):
  - Swap so that |A| >= |B|, comparing exponent then fraction.
  - Right-shift B's significand (hidden 1 restored) by the exponent difference.
  - Keep guard and round bits, plus a sticky OR of all bits shifted further. A shift of MAN_W+3 or more leaves B as sticky only.
- Stage 2 (add/normalise):
  - Add or subtract significands at width MAN_W+4 plus 1 carry bit.
  - On carry-out, shift right 1, increment the exponent, and fold the lost bit into sticky.
  - Otherwise left-normalise with a leading-zero count and decrement the exponent.
  - An exact zero difference gives +0, or -0 only when both operands are -0 (effective).
- Stage 3 (round/pack):
  - RNE: increment when G AND (R OR S OR lsb).
  - A mantissa overflow from rounding increments the exponent.
  - nx = G OR R OR S, or any flush-to-zero on the output.
  - Exponent >= all ones gives signed inf with of=1 and nx=1.
  - Exponent <= 0 gives signed zero with nx=1.

## Timing
- Three register stages. A pair accepted at edge N appears with out_valid=1 after edge N+3.
- Global stall: advance = !out_valid | out_ready, and in_ready = advance (combinational).
- All stage registers and the output register load only when advance=1. Bubbles propagate as valid=0.
- A transfer occurs on an edge where in_valid & in_ready (input side) or out_valid & out_ready (output side).
- Throughput is one result per cycle while out_ready=1.
- While out_valid=1 and out_ready=0, s and flags hold stable and no stage advances.
- Input accept and output drain may occur on the same edge; the pipeline stays full.
- in_valid=1 while in_ready=0: the operands are not captured, and the producer holds them.
- Reset values: out_valid=0, s=0, flags=0, all internal valids 0.
- Reset asserted mid-operation discards every in-flight pair with no output. in_ready=1 on the first cycle after reset deasserts, because out_valid=0.

## Test plan
- a=3F750000, b=3FC00000, sub=0, out_ready=1 -> after 3 cycles s=401D4000, flags=000.
- a=b=3FC00000, sub=1 -> s=00000000, flags=000; b=BFC00000 also with sub=0 -> same.
- RNE ties:
  - 3F800000 + 33800000 -> s=3F800000, nx=1.
  - 3F800001 + 33800000 -> s=3F800002, nx=1.
- Specials:
  - 7F7FFFFF + 7F7FFFFF -> 7F800000, flags=011.
  - 7F800000 - 7F800000 -> 7FC00000, flags=100.
  - 7F800001 + 3F800000 -> 7FC00000, nv=1.
  - 00400000 + 00000001 -> 00000000.
- Back-pressure:
  - Stream 8 pairs with in_valid=1 while toggling out_ready 1,0,0,1,...
  - Required: results in order, no loss or duplication; s held while stalled; in_ready low exactly when out_valid & !out_ready.
- Reset with 3 pairs in flight -> out_valid never asserts for them; next pair after reset yields its correct result 3 cycles after acceptance.
- Parametrised: EXP_W=5, MAN_W=10, a=3C00 + b=3C00 -> s=4000; a=7BFF + 7BFF -> 7C00, of=1.

Source files
------------

// File: rtl/fpadd_pipe.sv
// Pipelined IEEE-754 adder/subtractor: operand capture, unpack/align,
// add/normalise, round/pack; RNE rounding with flush-to-zero of subnormals.
module fpadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     s,
  output logic [2:0]               flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int EW = EXP_W + 2;  // exponent with sign and carry headroom

  localparam logic [W-1:0]     QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W:0]   SHMAX = (EXP_W+1)'(MAN_W + 3);
  localparam logic [EW-1:0]    EMAX  = EW'((1 << EXP_W) - 1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // operand capture
  logic         r0_valid;
  logic [W-1:0] r0_a, r0_b;
  logic         r0_sub;

  // stage 1: unpack / special detection / align
  logic               sa, sb, sl, ss;
  logic [EXP_W-1:0]   ea, eb, el, es, d;
  logic [MAN_W-1:0]   fa, fb, fl, fs;
  logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;
  logic [MAN_W:0]     sig_s;
  logic [2*M-3:0]     wide;
  logic [M-1:0]       c1_ma, c1_mb;
  logic               c1_spec, c1_spec_nv;
  logic [W-1:0]       c1_spec_res;

  always_comb begin
    sa = r0_a[W-1];
    ea = r0_a[W-2:MAN_W];
    fa = (r0_a[W-2:MAN_W] == '0) ? '0 : r0_a[MAN_W-1:0];
    sb = r0_b[W-1] ^ r0_sub;
    eb = r0_b[W-2:MAN_W];
    fb = (r0_b[W-2:MAN_W] == '0) ? '0 : r0_b[MAN_W-1:0];

    a_nan  = (&ea) && (|fa);
    b_nan  = (&eb) && (|fb);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    a_inf  = (&ea) && !(|fa);
    b_inf  = (&eb) && !(|fb);

    c1_spec     = a_nan || b_nan || a_inf || b_inf;
    c1_spec_nv  = 1'b0;
    c1_spec_res = QNAN;
    if (a_nan || b_nan) begin
      c1_spec_nv = a_snan || b_snan;
    end else if (a_inf && b_inf && (sa != sb)) begin
      c1_spec_nv = 1'b1;
    end else if (a_inf) begin
      c1_spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      c1_spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    swap = {eb, fb} > {ea, fa};
    sl = swap ? sb : sa;
    ss = swap ? sa : sb;
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    fl = swap ? fb : fa;
    fs = swap ? fa : fb;
    d  = el - es;

    sig_s = {es != '0, fs};
    wide  = {sig_s, 2'b00, {(M-1){1'b0}}} >> d;
    c1_ma = {el != '0, fl, 3'b000};
    if ({1'b0, d} >= SHMAX) begin
      c1_mb = {{(M-1){1'b0}}, |sig_s};
    end else begin
      c1_mb = {wide[2*M-3 -: M-1], |wide[M-2:0]};
    end
  end

  logic               s1_valid, s1_spec, s1_spec_nv, s1_sign, s1_sub, s1_zsign;
  logic [W-1:0]       s1_spec_res;
  logic [EXP_W-1:0]   s1_exp;
  logic [M-1:0]       s1_ma, s1_mb;

  // stage 2: add / normalise
  logic [M:0]     sum;
  logic [EW-1:0]  lz, c2_exp;
  logic [M-1:0]   c2_man;
  logic           found;

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      if (!found && sum[M-1-i]) begin
        found = 1'b1;
        lz    = EW'(i);
      end
    end
    if (sum[M]) begin
      c2_man = {sum[M:2], sum[1] | sum[0]};
      c2_exp = {2'b00, s1_exp} + EW'(1);
    end else begin
      c2_man = sum[M-1:0] << lz;
      c2_exp = {2'b00, s1_exp} - lz;
    end
  end

  logic               s2_valid, s2_spec, s2_spec_nv, s2_sign, s2_zero, s2_zsign;
  logic [W-1:0]       s2_spec_res;
  logic [EW-1:0]      s2_exp;
  logic [M-1:0]       s2_man;

  // stage 3: round / pack
  logic               g, r, st, inc, nx;
  logic [MAN_W+1:0]   rnd;
  logic [EW-1:0]      exp_r;
  logic [MAN_W-1:0]   frac;
  logic [W-1:0]       c3_s;
  logic [2:0]         c3_f;

  always_comb begin
    g   = s2_man[2];
    r   = s2_man[1];
    st  = s2_man[0];
    inc = g && (r || st || s2_man[3]);
    nx  = g || r || st;
    rnd   = {1'b0, s2_man[M-1:3]} + (MAN_W+2)'(inc);
    exp_r = s2_exp + EW'(rnd[MAN_W+1]);
    frac  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    if (s2_spec) begin
      c3_s = s2_spec_res;
      c3_f = {s2_spec_nv, 2'b00};
    end else if (s2_zero) begin
      c3_s = {s2_zsign, {(W-1){1'b0}}};
      c3_f = 3'b000;
    end else if (!exp_r[EW-1] && (exp_r >= EMAX)) begin
      c3_s = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c3_f = 3'b011;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      c3_s = {s2_sign, {(W-1){1'b0}}};
      c3_f = 3'b001;
    end else begin
      c3_s = {s2_sign, exp_r[EXP_W-1:0], frac};
      c3_f = {2'b00, nx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      flags     <= '0;
    end else if (advance) begin
      r0_valid <= in_valid;
      r0_a     <= a;
      r0_b     <= b;
      r0_sub   <= sub;

      s1_valid    <= r0_valid;
      s1_spec     <= c1_spec;
      s1_spec_nv  <= c1_spec_nv;
      s1_spec_res <= c1_spec_res;
      s1_sign     <= sl;
      s1_sub      <= sl ^ ss;
      s1_zsign    <= sa & sb;
      s1_exp      <= el;
      s1_ma       <= c1_ma;
      s1_mb       <= c1_mb;

      s2_valid    <= s1_valid;
      s2_spec     <= s1_spec;
      s2_spec_nv  <= s1_spec_nv;
      s2_spec_res <= s1_spec_res;
      s2_sign     <= s1_sign;
      s2_zsign    <= s1_zsign;
      s2_zero     <= (sum == '0);
      s2_exp      <= c2_exp;
      s2_man      <= c2_man;

      out_valid <= s2_valid;
      s         <= s2_valid ? c3_s : '0;
      flags     <= s2_valid ? c3_f : '0;
    end
  end

endmodule

// File: tb/tb_fpadd_pipe.sv
// Scoreboard bench for fpadd_pipe: binary32 instance plus a binary16 instance.
module tb_fpadd_pipe;

  typedef struct packed {
    logic [31:0] s;
    logic [2:0]  f;
    logic [7:0]  id;
  } exp_t;

  typedef struct packed {
    logic [15:0] s;
    logic [2:0]  f;
    logic [7:0]  id;
  } exph_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, sub = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, s;
  logic [2:0]  flags;

  logic        h_in_valid = 1'b0, h_in_ready, h_sub = 1'b0, h_out_valid, h_out_ready = 1'b1;
  logic [15:0] h_a = '0, h_b = '0, h_s;
  logic [2:0]  h_flags;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];
  exph_t       qh[$];

  localparam int NV = 17;
  logic [31:0] ta [NV] = '{32'h3F750000, 32'h3FC00000, 32'h3FC00000, 32'h3F800000, 32'h3F800001,
                           32'h7F7FFFFF, 32'h7F800000, 32'h7F800001, 32'h00400000, 32'h40000000,
                           32'h3F800000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h3FFFFFFF,
                           32'h00800001, 32'h3F800000};
  logic [31:0] tb [NV] = '{32'h3FC00000, 32'h3FC00000, 32'hBFC00000, 32'h33800000, 32'h33800000,
                           32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h00000001, 32'h3F800000,
                           32'hBF800000, 32'h80000000, 32'h3F800000, 32'h7F7FFFFF, 32'h33800000,
                           32'h00800000, 32'h00000000};
  logic        tsb [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                            1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] tsr [NV] = '{32'h401D4000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h3F800002,
                           32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h3F800000,
                           32'h40000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h40000000,
                           32'h00000000, 32'h3F800000};
  logic [2:0]  tfl [NV] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b011, 3'b100, 3'b100, 3'b000,
                            3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000};

  localparam int NH = 5;
  logic [15:0] ha  [NH] = '{16'h3C00, 16'h7BFF, 16'h3C00, 16'h7C00, 16'h3C00};
  logic [15:0] hb  [NH] = '{16'h3C00, 16'h7BFF, 16'h3C00, 16'h7C00, 16'h3800};
  logic        hsb [NH] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] hsr [NH] = '{16'h4000, 16'h7C00, 16'h0000, 16'h7E00, 16'h3E00};
  logic [2:0]  hfl [NH] = '{3'b000, 3'b011, 3'b000, 3'b100, 3'b000};

  fpadd_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .flags(flags)
  );

  fpadd_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .s(h_s), .flags(h_flags)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== 32'h0 || flags !== 3'b000) begin
      failures++;
      $display("FAIL reset_state got valid=%b s=%h flags=%b required valid=0 s=00000000 flags=000",
               out_valid, s, flags);
    end
    checks++;
    if (h_out_valid !== 1'b0 || h_s !== 16'h0) begin
      failures++;
      $display("FAIL reset_state16 got valid=%b s=%h required valid=0 s=0000", h_out_valid, h_s);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int unsigned idx = 0, got = 0, budget = 0, acc_cyc = 0;
    exp_t e;
    out_ready = 1'b1;
    while (got < NV && budget < 200) begin
      @(posedge clk); #1;
      in_valid = (idx < NV);
      if (idx < NV) begin a = ta[idx]; b = tb[idx]; sub = tsb[idx]; end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL basic_extra got s=%h with empty scoreboard", s);
        end else begin
          e = q.pop_front();
          if (s !== e.s || flags !== e.f) begin
            failures++;
            $display("FAIL basic[%0d] got s=%h flags=%b required s=%h flags=%b", e.id, s, flags, e.s, e.f);
          end
          if (got == 0) begin
            checks++;
            if (cyc != acc_cyc + 3) begin
              failures++;
              $display("FAIL latency got %0d cycles required 3", cyc - acc_cyc);
            end
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{s: tsr[idx], f: tfl[idx], id: 8'(idx)});
        if (idx == 0) acc_cyc = cyc + 1;
        idx++;
      end
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != NV) begin
      failures++;
      $display("FAIL basic_timeout got %0d results required %0d", got, NV);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned idx = 0, got = 0, budget = 0, k = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_s = '0;
    logic [2:0] prev_f = '0;
    exp_t e;
    q.delete();
    while (got < 8 && budget < 200) begin
      @(posedge clk); #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || s !== prev_s || flags !== prev_f) begin
          failures++;
          $display("FAIL bp_hold got valid=%b s=%h required valid=1 s=%h", out_valid, s, prev_s);
        end
      end
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
      in_valid = (idx < 8);
      if (idx < 8) begin a = ta[idx]; b = tb[idx]; sub = tsb[idx]; end
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++;
        $display("FAIL bp_in_ready got %b required %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra got s=%h with empty scoreboard", s);
        end else begin
          e = q.pop_front();
          if (s !== e.s || flags !== e.f) begin
            failures++;
            $display("FAIL bp[%0d] got s=%h flags=%b required s=%h flags=%b", e.id, s, flags, e.s, e.f);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{s: tsr[idx], f: tfl[idx], id: 8'(idx)});
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_s = s;
      prev_f = flags;
      budget++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 8 || q.size() != 0) begin
      failures++;
      $display("FAIL bp_count got %0d results (%0d pending) required 8 (0)", got, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    int unsigned budget = 0, acc_cyc = 0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = ta[i]; b = tb[i]; sub = tsb[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready got %b required 1", in_ready);
    end
    for (int unsigned i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_flush got out_valid=1 required 0 for discarded pairs");
    end
    in_valid = 1'b1; a = ta[14]; b = tb[14]; sub = tsb[14];
    #1;
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && budget < 10) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL rst_next_timeout got no output required one");
    end else begin
      if (cyc != acc_cyc + 3) begin
        failures++;
        $display("FAIL rst_next_latency got %0d required 3", cyc - acc_cyc);
      end
      checks++;
      if (s !== tsr[14] || flags !== tfl[14]) begin
        failures++;
        $display("FAIL rst_next got s=%h flags=%b required s=%h flags=%b", s, flags, tsr[14], tfl[14]);
      end
    end
  endtask

  task automatic test_param();
    int unsigned idx = 0, got = 0, budget = 0;
    exph_t e;
    h_out_ready = 1'b1;
    while (got < NH && budget < 100) begin
      @(posedge clk); #1;
      h_in_valid = (idx < NH);
      if (idx < NH) begin h_a = ha[idx]; h_b = hb[idx]; h_sub = hsb[idx]; end
      #1;
      if (h_out_valid && h_out_ready) begin
        checks++;
        if (qh.size() == 0) begin
          failures++;
          $display("FAIL half_extra got s=%h with empty scoreboard", h_s);
        end else begin
          e = qh.pop_front();
          if (h_s !== e.s || h_flags !== e.f) begin
            failures++;
            $display("FAIL half[%0d] got s=%h flags=%b required s=%h flags=%b", e.id, h_s, h_flags, e.s, e.f);
          end
        end
        got++;
      end
      if (h_in_valid && h_in_ready) begin
        qh.push_back('{s: hsr[idx], f: hfl[idx], id: 8'(idx)});
        idx++;
      end
      budget++;
    end
    h_in_valid = 1'b0;
    checks++;
    if (got != NH) begin
      failures++;
      $display("FAIL half_timeout got %0d results required %0d", got, NH);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_midflight();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
